button_conditioner: RTL

Front-end conditioning stage for the board push-buttons: it feeds the stopwatch/lap-memory controller. For every button it:
- synchronises the raw, bouncing, active-low key input into `clk`;
- debounces it with a stability counter;
- delivers a clean active-high level plus single-cycle press and release strobes.

The controller consumes the strobes directly and needs no edge-detection logic of its own.

---
 rtl/button_conditioner_if.sv | 47 ++++
 rtl/button_conditioner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Signal bundle between the push-button pins and the stopwatch
//               controller. The raw active-low keys flow into the conditioner
//               and the clean level / strobe outputs flow back out.
//
//               The release strobe is named release_pulse because "release"
//               is a reserved SystemVerilog keyword (force/release).
//
//   btn_n          N_BTN  raw keys, active-low, asynchronous, bouncing
//   level          N_BTN  debounced pressed state, 1 = pressed
//   press          N_BTN  one-cycle press strobe (plus auto-repeat if built)
//   release_pulse  N_BTN  one-cycle release strobe
//   any_press      1      OR of all press bits, same cycle as press
//
//   modport master : board / controller side (drives btn_n, reads outputs)
//   modport slave  : conditioner side
//
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_pulse;
    logic             any_press;

    modport master (
        output btn_n,
        input  level,
        input  press,
        input  release_pulse,
        input  any_press
    );

    modport slave (
        input  btn_n,
        output level,
        output press,
        output release_pulse,
        output any_press
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-button synchroniser, debouncer and edge-strobe generator
//               for the board push-buttons. Each channel is independent:
//               two-flop synchroniser, stability counter, four-state FSM
//               (RELEASED / PRESS_PEND / PRESSED / REL_PEND) and registered
//               level, press and release outputs.
//
//   Ports
//     clk    in   single clock, rising edge
//     reset  in   synchronous active-high reset (wins over everything)
//     btn    slave modport of button_conditioner_if:
//              btn_n, level, press, release_pulse, any_press
//
//   Parameters
//     N_BTN           number of channels
//     DEBOUNCE_CYCLES stable cycles before a level change is accepted (>= 2)
//     HOLD_CYCLES     hold time to first auto-repeat strobe
//     REPEAT_CYCLES   period of subsequent auto-repeat strobes
//
//   Build option
//     BTN_AUTOREPEAT_EN  when defined, each channel gets a hold counter and
//                        emits extra press strobes while the key is held.
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    button_conditioner_if.slave    btn
);

    typedef enum logic [1:0] {
        S_RELEASED   = 2'd0,
        S_PRESS_PEND = 2'd1,
        S_PRESSED    = 2'd2,
        S_REL_PEND   = 2'd3
    } state_t;

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_hold_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_hold_w   = $clog2(c_hold_max) + 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_rep_last  = c_hold_w'(REPEAT_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
`endif

    logic [N_BTN-1:0] w_level_vec;
    logic [N_BTN-1:0] w_press_vec;
    logic [N_BTN-1:0] w_rel_vec;
    logic [N_BTN-1:0] w_press_nxt_vec;
    logic             r_any_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic               r_s1;
        logic               r_s2;
        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_cnt_w-1:0] r_cnt;
        logic [c_cnt_w-1:0] w_cnt_nxt;
        logic               r_level;
        logic               w_level_nxt;
        logic               r_press;
        logic               w_press_nxt;
        logic               r_rel;
        logic               w_rel_nxt;
        logic               w_rep_due;

        // Two-flop synchroniser; inversion makes s1/s2 active-high "pressed".
        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= ~btn.btn_n[i];
                r_s2 <= r_s1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_RELEASED;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_press <= w_press_nxt;
                r_rel   <= w_rel_nxt;
            end
        end

        // The counter holds the number of consecutive cycles s2 has disagreed
        // with the accepted level. Reaching the last count while still
        // disagreeing commits the transition instead of wrapping.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_press_nxt = 1'b0;
            w_rel_nxt   = 1'b0;
            case (r_state)
                S_RELEASED: begin
                    w_cnt_nxt = '0;
                    if (r_s2) begin
                        w_state_nxt = S_PRESS_PEND;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                S_PRESS_PEND: begin
                    if (!r_s2) begin
                        w_state_nxt = S_RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
                S_PRESSED: begin
                    w_cnt_nxt   = '0;
                    w_press_nxt = w_rep_due;
                    if (!r_s2) begin
                        w_state_nxt = S_REL_PEND;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
                S_REL_PEND: begin
                    if (r_s2) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_nxt = w_rep_due;
                    end else if (r_cnt == c_cnt_last) begin
                        // Release wins: a repeat due on this very edge is
                        // dropped so press and release never coincide.
                        w_state_nxt = S_RELEASED;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                        w_press_nxt = w_rep_due;
                    end
                end
                default: begin
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [c_hold_w-1:0] r_hold;
        logic                r_rep_phase;   // 0: waiting for first repeat
        logic                w_held;

        assign w_held    = (r_state == S_PRESSED) || (r_state == S_REL_PEND);
        assign w_rep_due = w_held && (r_rep_phase ? (r_hold == c_rep_last)
                                                  : (r_hold == c_hold_last));

        // Restarted only by a fresh accepted press; a release bounce that
        // falls back into PRESSED keeps the running hold time.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b0;
            end else if (r_state == S_PRESS_PEND && w_state_nxt == S_PRESSED) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_held) begin
                if (w_rep_due) begin
                    r_hold      <= '0;
                    r_rep_phase <= 1'b1;
                end else begin
                    r_hold      <= r_hold + c_hold_one;
                end
            end
        end
`else
        // Repeat timing is not built; the expression is constant-false and
        // only keeps the unused timing parameters referenced.
        assign w_rep_due = (HOLD_CYCLES < 0) && (REPEAT_CYCLES < 0);
`endif

        assign w_level_vec[i]     = r_level;
        assign w_press_vec[i]     = r_press;
        assign w_rel_vec[i]       = r_rel;
        assign w_press_nxt_vec[i] = w_press_nxt;
    end

    // Built from next-state press bits so it rises on the same edge as press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt_vec;
        end
    end

    assign btn.level         = w_level_vec;
    assign btn.press         = w_press_vec;
    assign btn.release_pulse = w_rel_vec;
    assign btn.any_press     = r_any_press;

endmodule
`default_nettype wire
